// File: rtl/button_input_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_input_pkg
// Description : Shared FSM encoding and 12 MHz default timing constants for
//               the push-button reader.
// Revision    : 1.0 - initial release
// ============================================================================
package button_input_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } btn_state_t;

    localparam int C_DEBOUNCE_CYCLES   = 12000;
    localparam int C_LONG_PRESS_CYCLES = 12000000;

endpackage
`default_nettype wire

// File: rtl/button_input_if.sv
`default_nettype none
// ============================================================================
// Module      : button_if
// Description : Event/level bundle from the button reader to LED/mode logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_if;

    logic       pressed;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press_pulse;
    logic [7:0] click_count;

    modport master (
        output pressed,
        output press_pulse,
        output release_pulse,
        output long_press_pulse,
        output click_count
    );

    modport slave (
        input pressed,
        input press_pulse,
        input release_pulse,
        input long_press_pulse,
        input click_count
    );

endinterface
`default_nettype wire

// File: rtl/button_input_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_input_sync_debounce
// Description : Polarity normalisation, 2-flop synchroniser and debounce
//               counter for one raw pin; reusable per button.
// Revision    : 1.0 - initial release
// ============================================================================
module button_input_sync_debounce
    import button_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  wire logic clock_12mhz,
    input  wire logic reset_n,
    input  wire logic i_button_raw,
    output logic      o_stable_level,
    output logic      o_level_change
);

    localparam int                  C_CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [C_CNT_W-1:0]  C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               w_level;
    logic [1:0]         r_sync;
    logic               r_stable;
    logic [C_CNT_W-1:0] r_cnt;

    assign w_level = i_button_raw ^ ACTIVE_LOW;

    always_ff @(posedge clock_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_sync   <= 2'b00;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync <= {r_sync[0], w_level};
            // Any agreeing sample restarts the run of differing samples.
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_stable <= r_sync[1];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Asserted on the very edge that flips r_stable so the FSM reacts in step.
    assign o_level_change = (r_sync[1] != r_stable) && (r_cnt == C_CNT_LAST);
    assign o_stable_level = r_stable;

endmodule
`default_nettype wire

// File: rtl/button_input.sv
`default_nettype none
// ============================================================================
// Module      : button_input
// Description : Debounced button reader: level, press/release/long-press
//               strobes and a wrapping short-click counter.
// Revision    : 1.0 - initial release
// ============================================================================
module button_input
    import button_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = C_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = C_LONG_PRESS_CYCLES,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  wire logic clock_12mhz,
    input  wire logic reset_n,
    input  wire logic button_raw,
    button_if.master  btn
);

    localparam int                   C_HOLD_W    = $clog2(LONG_PRESS_CYCLES) + 1;
    localparam logic [C_HOLD_W-1:0]  C_HOLD_LAST = C_HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic                w_stable_level;
    logic                w_level_change;
    btn_state_t          r_state;
    logic [C_HOLD_W-1:0] r_hold;
    logic                r_pressed;
    logic                r_press_pulse;
    logic                r_release_pulse;
    logic                r_long_pulse;
    logic [7:0]          r_click_count;

    button_input_sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_sync_debounce (
        .clock_12mhz    (clock_12mhz),
        .reset_n        (reset_n),
        .i_button_raw   (button_raw),
        .o_stable_level (w_stable_level),
        .o_level_change (w_level_change)
    );

    always_ff @(posedge clock_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_hold          <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_click_count   <= 8'd0;
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_level_change) begin
                        r_state       <= ST_HELD;
                        r_pressed     <= 1'b1;
                        r_press_pulse <= 1'b1;
                        r_hold        <= '0;
                    end
                end
                ST_HELD: begin
                    // Release is checked first so it wins over the long threshold.
                    if (w_level_change) begin
                        r_state         <= ST_IDLE;
                        r_pressed       <= 1'b0;
                        r_release_pulse <= 1'b1;
                        r_click_count   <= r_click_count + 8'd1;
                    end else if (r_hold == C_HOLD_LAST) begin
                        r_state      <= ST_LONG;
                        r_long_pulse <= 1'b1;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                ST_LONG: begin
                    if (w_level_change) begin
                        r_state         <= ST_IDLE;
                        r_pressed       <= 1'b0;
                        r_release_pulse <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_pressed <= 1'b0;
                end
            endcase
        end
    end

    assign btn.pressed          = r_pressed;
    assign btn.press_pulse      = r_press_pulse;
    assign btn.release_pulse    = r_release_pulse;
    assign btn.long_press_pulse = r_long_pulse;
    assign btn.click_count      = r_click_count;

endmodule
`default_nettype wire

// File: tb/tb_button_input.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_input
// Description : Directed, self-checking bench for button_input against a
//               window-based behavioural model of the debounced button.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_input;

    localparam int C_DB = 4;
    localparam int C_LP = 20;

    logic clock_12mhz;
    logic reset_n;
    logic button_raw;

    button_if btn_bus ();

    button_input #(
        .DEBOUNCE_CYCLES   (C_DB),
        .LONG_PRESS_CYCLES (C_LP),
        .ACTIVE_LOW        (1'b1)
    ) dut (
        .clock_12mhz (clock_12mhz),
        .reset_n     (reset_n),
        .button_raw  (button_raw),
        .btn         (btn_bus)
    );

    initial begin
        clock_12mhz = 1'b0;
        forever #5 clock_12mhz = ~clock_12mhz;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_press  = 0;
    int n_rel    = 0;
    int n_long   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: the stable level flips once the last C_DB synchronised
    // samples all disagree with it; a synchronised sample is the pin two edges ago.
    bit lvl_q[$];
    bit syn_q[$];
    bit m_stable, m_press, m_rel, m_long, m_long_done;
    int m_age;
    int m_clicks;

    task automatic model_reset();
        lvl_q.delete();
        syn_q.delete();
        m_stable = 0; m_press = 0; m_rel = 0; m_long = 0; m_long_done = 0;
        m_age = 0; m_clicks = 0;
    endtask

    task automatic model_step(input bit lvl);
        bit syn, flip;
        lvl_q.push_back(lvl);
        if (lvl_q.size() > 3) void'(lvl_q.pop_front());
        syn = (lvl_q.size() == 3) ? lvl_q[0] : 1'b0;
        syn_q.push_back(syn);
        if (syn_q.size() > C_DB) void'(syn_q.pop_front());
        flip = (syn_q.size() == C_DB);
        foreach (syn_q[i]) if (syn_q[i] == m_stable) flip = 0;
        m_press = 0; m_rel = 0; m_long = 0;
        if (flip) begin
            m_stable = !m_stable;
            if (m_stable) begin
                m_press = 1; m_age = 0; m_long_done = 0;
            end else begin
                m_rel = 1;
                if (!m_long_done) m_clicks = (m_clicks + 1) % 256;
            end
        end else if (m_stable) begin
            m_age++;
            if (m_age == C_LP && !m_long_done) begin
                m_long = 1; m_long_done = 1;
            end
        end
    endtask

    // Model update and per-cycle comparison, half a cycle after each edge.
    initial begin
        bit smp_raw, smp_rst;
        model_reset();
        forever begin
            @(posedge clock_12mhz);
            smp_raw = button_raw;
            smp_rst = reset_n;
            @(negedge clock_12mhz);
            if (!reset_n)     model_reset();
            else if (smp_rst) model_step(~smp_raw);
            check("pressed",      int'(btn_bus.pressed),          int'(m_stable));
            check("press_pulse",  int'(btn_bus.press_pulse),      int'(m_press));
            check("release_pulse",int'(btn_bus.release_pulse),    int'(m_rel));
            check("long_pulse",   int'(btn_bus.long_press_pulse), int'(m_long));
            check("click_count",  int'(btn_bus.click_count),      m_clicks);
            n_press += int'(btn_bus.press_pulse);
            n_rel   += int'(btn_bus.release_pulse);
            n_long  += int'(btn_bus.long_press_pulse);
        end
    end

    task automatic drive_raw(input logic v);
        @(posedge clock_12mhz);
        #2 button_raw = v;
    endtask

    // Cycles counted from the edge preceding the call; -1 on timeout.
    task automatic wait_pulse(input int sel, input int limit, output int cycles);
        logic hit;
        hit = 1'b0;
        cycles = 0;
        while (!hit && cycles < limit) begin
            @(posedge clock_12mhz);
            #1;
            cycles++;
            case (sel)
                0:       hit = btn_bus.press_pulse;
                1:       hit = btn_bus.release_pulse;
                2:       hit = btn_bus.long_press_pulse;
                default: hit = 1'b0;
            endcase
        end
        if (!hit) cycles = -1;
    endtask

    task automatic settle();
        @(negedge clock_12mhz);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, base;
        reset_n    = 1'b0;
        button_raw = 1'b0;

        // Reset with the pin at its pressed level
        repeat (3) @(posedge clock_12mhz);
        #1;
        check("rst_pressed", int'(btn_bus.pressed), 0);
        check("rst_press",   int'(btn_bus.press_pulse), 0);
        check("rst_release", int'(btn_bus.release_pulse), 0);
        check("rst_long",    int'(btn_bus.long_press_pulse), 0);
        check("rst_clicks",  int'(btn_bus.click_count), 0);
        drive_raw(1'b1);
        @(posedge clock_12mhz);
        #2 reset_n = 1'b1;
        repeat (50) @(posedge clock_12mhz);
        settle();
        check("idle_presses", n_press, 0);
        check("idle_clicks",  int'(btn_bus.click_count), 0);

        // Clean short click
        drive_raw(1'b0);
        wait_pulse(0, 40, cyc);
        check("click_press_lat", cyc, 6);
        repeat (3) @(posedge clock_12mhz);
        drive_raw(1'b1);
        wait_pulse(1, 40, cyc);
        check("click_release_lat", cyc, 6);
        settle();
        check("click_count_1", int'(btn_bus.click_count), 1);
        check("click_no_long", n_long, 0);

        // Bounce: 2-cycle runs, then a final settle to pressed
        repeat (5) @(posedge clock_12mhz);
        base = n_press;
        for (int i = 0; i < 10; i++) begin
            drive_raw((i % 2 == 0) ? 1'b0 : 1'b1);
            @(posedge clock_12mhz);
        end
        drive_raw(1'b0);
        wait_pulse(0, 40, cyc);
        check("bounce_press_lat", cyc, 6);
        settle();
        check("bounce_one_press", n_press - base, 1);
        drive_raw(1'b1);
        wait_pulse(1, 40, cyc);
        check("bounce_release_lat", cyc, 6);
        settle();
        check("click_count_2", int'(btn_bus.click_count), 2);

        // Long press
        repeat (5) @(posedge clock_12mhz);
        drive_raw(1'b0);
        wait_pulse(0, 40, cyc);
        check("long_press_lat", cyc, 6);
        wait_pulse(2, 40, cyc);
        check("long_after_press", cyc, 20);
        repeat (12) @(posedge clock_12mhz);
        drive_raw(1'b1);
        wait_pulse(1, 40, cyc);
        check("long_release_lat", cyc, 6);
        settle();
        check("long_click_unchanged", int'(btn_bus.click_count), 2);
        check("long_count", n_long, 1);

        // Release lands on the long threshold cycle: counts as a short click
        repeat (5) @(posedge clock_12mhz);
        drive_raw(1'b0);
        wait_pulse(0, 40, cyc);
        repeat (14) @(posedge clock_12mhz);
        #1 button_raw = 1'b1;
        wait_pulse(1, 40, cyc);
        check("race_release_lat", cyc, 6);
        repeat (30) @(posedge clock_12mhz);
        settle();
        check("race_no_long", n_long, 1);
        check("click_count_3", int'(btn_bus.click_count), 3);

        // Wrap-around of the click counter
        for (int i = 0; i < 256; i++) begin
            drive_raw(1'b0);
            repeat (8) @(posedge clock_12mhz);
            drive_raw(1'b1);
            repeat (8) @(posedge clock_12mhz);
            if (i == 252) begin
                #1;
                check("wrap_to_zero", int'(btn_bus.click_count), 0);
            end
        end
        settle();
        check("wrap_256", int'(btn_bus.click_count), 3);

        // Reset while pressed
        drive_raw(1'b0);
        wait_pulse(0, 40, cyc);
        repeat (3) @(posedge clock_12mhz);
        base = n_rel;
        #2 reset_n = 1'b0;
        #1;
        check("midrst_pressed", int'(btn_bus.pressed), 0);
        check("midrst_clicks",  int'(btn_bus.click_count), 0);
        repeat (2) @(posedge clock_12mhz);
        #2 reset_n = 1'b1;
        wait_pulse(0, 40, cyc);
        check("midrst_repress_lat", cyc, 6);
        settle();
        check("midrst_no_release", n_rel - base, 0);
        drive_raw(1'b1);
        wait_pulse(1, 40, cyc);
        check("final_release_lat", cyc, 6);
        repeat (5) @(posedge clock_12mhz);
        settle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_input.md
# button_input

Debounced push-button reader for the iCE40UP5k board: the input-side counterpart to the LED output logic. Synchronizes one raw button pin into the clock_12mhz domain, filters contact bounce, and emits a debounced level plus single-cycle press, release and long-press events and a short-click counter for downstream LED/mode logic.

## Interface
- DEBOUNCE_CYCLES, 12000: consecutive stable synchronized samples required to accept a level change (1 ms at 12 MHz); legal range ≥ 2.
- LONG_PRESS_CYCLES, 12000000: cycles of debounced hold before long_press_pulse fires (1 s); must exceed DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1: 1 means pin low = pressed; 0 means pin high = pressed.
- clock_12mhz  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- button_raw  in  1  asynchronous pin from the board, may bounce.
- pressed  out  1  debounced level, 1 = button held.
- press_pulse  out  1  one-cycle strobe when pressed goes 0→1.
- release_pulse  out  1  one-cycle strobe when pressed goes 1→0.
- long_press_pulse  out  1  one-cycle strobe, at most once per press.
- click_count  out  8  count of short clicks, wraps 255→0.

## Operation
- Input normalized: level = button_raw XOR ACTIVE_LOW, so 1 = pressed.
- Two-flop synchronizer; both flops reset to 0 (not pressed).
- Debounce counter (width clog2(DEBOUNCE_CYCLES)+1): cleared whenever synced sample equals stable level; increments while it differs; when counter = DEBOUNCE_CYCLES−1 and sample still differs, stable level flips and counter clears.
- FSM states: IDLE (released), HELD (pressed, long not yet fired), LONG (pressed, long fired).
  - IDLE → HELD on stable 0→1: press_pulse=1, hold counter cleared.
  - HELD: hold counter increments each cycle; at count = LONG_PRESS_CYCLES−1 → LONG with long_press_pulse=1.
  - HELD → IDLE on stable 1→0: release_pulse=1, click_count+1.
  - LONG → IDLE on stable 1→0: release_pulse=1, click_count unchanged.
- Hold counter (width clog2(LONG_PRESS_CYCLES)+1) stops in LONG; never wraps.
- pressed = 1 in HELD and LONG.

## Timing
- Reset values: pressed 0, all pulses 0, click_count 0, FSM IDLE, all counters 0, synchronizer 0.
- Latency: a raw level change settled before rising edge N yields pressed change and press/release_pulse at output after edge N+1+DEBOUNCE_CYCLES (2 sync stages + DEBOUNCE_CYCLES samples).
- Bounce: any differing run shorter than DEBOUNCE_CYCLES produces no output change; a single agreeing sample restarts the count.
- long_press_pulse asserted exactly LONG_PRESS_CYCLES cycles after press_pulse.
- Pulses are registered outputs, high exactly one cycle; press and release never in the same cycle; long_press_pulse never coincides with release_pulse (release wins: HELD exits to IDLE if stable release and long threshold hit in the same cycle, counted as short click).
- Button held through reset deassertion: treated as a fresh press; press_pulse after normal latency.
- reset_n asserted mid-press: all state clears immediately; no release_pulse is emitted.

## Structure
- Shared package: FSM state encoding (IDLE, HELD, LONG), default constants for 12 MHz (DEBOUNCE_CYCLES, LONG_PRESS_CYCLES).
- Sub-module sync_debounce: normalization, 2-flop synchronizer and debounce counter, outputting stable level; reusable for further buttons. button_input holds FSM, hold counter, pulses and click_count.

## Test plan
Parameters for bench: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=1.
- Reset: reset_n=0 with button_raw=0 → all outputs 0; release reset, hold raw 1 for 50 cycles → no pulses, click_count 0.
- Clean short click: raw 0 for 10 cycles then 1 → press_pulse 6 cycles after the change, release_pulse 6 cycles after the return, click_count=1, no long_press_pulse.
- Bounce: raw toggles every 2 cycles for 20 cycles, then stays 0 → exactly one press_pulse, 6 cycles after the final edge.
- Long press: raw 0 for 40 cycles → press_pulse, long_press_pulse 20 cycles later, one release_pulse after return; click_count unchanged.
- Wrap: 256 short clicks → click_count returns to 0.
- Reset mid-press: assert reset_n=0 while pressed=1 → pressed 0 immediately, no release_pulse; raw still 0 after release → new press_pulse after 6 cycles.
